// File: rtl/button_event_gen_pkg.sv
// Shared types and polarity helpers for the button event generator.
package button_event_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    localparam logic ACTIVE_LOW_LVL  = 1'b0;
    localparam logic ACTIVE_HIGH_LVL = 1'b1;

    // Level the debouncer idles at when the button is not pressed.
    function automatic logic inactive_level(input bit active_low);
        return active_low ? ACTIVE_HIGH_LVL : ACTIVE_LOW_LVL;
    endfunction

endpackage

// File: rtl/button_event_gen_sync_edge_detect.sv
// Two-stage level register with combinational rise/fall detection on the registered level.
module sync_edge_detect #(
    parameter logic RESET_LVL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_lvl_q;
    logic r_lvl_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lvl_q    <= RESET_LVL;
            r_lvl_prev <= RESET_LVL;
        end else begin
            r_lvl_q    <= i_level;
            r_lvl_prev <= r_lvl_q;
        end
    end

    assign o_rise = r_lvl_q & ~r_lvl_prev;
    assign o_fall = ~r_lvl_q & r_lvl_prev;

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press/release/long/repeat pulses plus a held flag.
module button_event_gen
    import button_event_gen_pkg::*;
#(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned LONG_CYCLES   = 1000,
    parameter int unsigned REPEAT_CYCLES = 250,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic p_level,
    input  logic p_enable,
    output logic p_press,
    output logic p_release,
    output logic p_long,
    output logic p_repeat,
    output logic p_held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST =
        (REPEAT_CYCLES == 0) ? '0 : CNT_W'(REPEAT_CYCLES - 1);

    logic w_rise;
    logic w_fall;
    logic w_press_edge;
    logic w_release_edge;

    sync_edge_detect #(
        .RESET_LVL(inactive_level(ACTIVE_LOW))
    ) u_sync_edge_detect (
        .clk    (clk),
        .reset_n(reset_n),
        .i_level(p_level),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_press_edge   = ACTIVE_LOW ? w_fall : w_rise;
    assign w_release_edge = ACTIVE_LOW ? w_rise : w_fall;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_press, r_release, r_long, r_repeat, r_held;
    logic             w_press, w_release, w_long, w_repeat;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        if (!p_enable) begin
            // Disable drops straight to IDLE silently; edges seen meanwhile are lost.
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_press_edge) begin
                        w_state_nxt = PRESS;
                        w_press     = 1'b1;
                        w_cnt_nxt   = '0;
                    end
                end
                PRESS: begin
                    if (w_release_edge) begin
                        w_state_nxt = IDLE;
                        w_release   = 1'b1;
                    end else if (r_cnt == LONG_LAST) begin
                        w_state_nxt = LONG;
                        w_long      = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (w_release_edge) begin
                        w_state_nxt = IDLE;
                        w_release   = 1'b1;
                    end else if (REPEAT_CYCLES != 0 && r_cnt == REPEAT_LAST) begin
                        w_repeat  = 1'b1;
                        w_cnt_nxt = '0;
                    end else if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_held    <= (w_state_nxt != IDLE);
        end
    end

    assign p_press   = r_press;
    assign p_release = r_release;
    assign p_long    = r_long;
    assign p_repeat  = r_repeat;
    assign p_held    = r_held;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen: vector table plus hand-written multi-cycle sequences.
module tb_button_event_gen;

    logic clk = 1'b0;
    logic reset_n;
    logic p_level, p_enable;
    logic p_press, p_release, p_long, p_repeat, p_held;
    logic q_level, q_enable;
    logic q_press, q_release, q_long, q_repeat, q_held;
    logic [4:0] o1, o2;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [4:0] E0  = 5'b00000;
    localparam logic [4:0] EPH = 5'b10001;
    localparam logic [4:0] EH  = 5'b00001;
    localparam logic [4:0] ER  = 5'b01000;
    localparam logic [4:0] ELH = 5'b00101;

    always #5 clk = ~clk;

    button_event_gen #(
        .ACTIVE_LOW(1'b1), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .p_level(p_level), .p_enable(p_enable),
        .p_press(p_press), .p_release(p_release), .p_long(p_long),
        .p_repeat(p_repeat), .p_held(p_held)
    );

    button_event_gen #(
        .ACTIVE_LOW(1'b0), .LONG_CYCLES(8), .REPEAT_CYCLES(0), .CNT_W(8)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .p_level(q_level), .p_enable(q_enable),
        .p_press(q_press), .p_release(q_release), .p_long(q_long),
        .p_repeat(q_repeat), .p_held(q_held)
    );

    assign o1 = {p_press, p_release, p_long, p_repeat, p_held};
    assign o2 = {q_press, q_release, q_long, q_repeat, q_held};

    typedef struct {
        logic       lvl;
        logic       en;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic lvl, input logic en, input logic [4:0] exp);
        vec_t v;
        v.lvl = lvl; v.en = en; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {press,rel,long,rep,held}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp;

        reset_n  = 1'b0;
        p_level  = 1'b1;
        p_enable = 1'b1;
        q_level  = 1'b0;
        q_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset dut", o1, E0);
        check("reset dut_sat", o2, E0);
        reset_n = 1'b1;

        // Long hold: press sampled at edge 10, release sampled at edge 40.
        for (int e = 1; e <= 45; e++) begin
            p_level = (e >= 10 && e <= 39) ? 1'b0 : 1'b1;
            step();
            exp[4] = (e == 11);
            exp[3] = (e == 41);
            exp[2] = (e == 19);
            exp[1] = (e == 23 || e == 27 || e == 31 || e == 35 || e == 39);
            exp[0] = (e >= 11 && e <= 40);
            check($sformatf("hold edge %0d", e), o1, exp);
        end

        // Short press of 3 cycles.
        add(1, 1, E0); add(0, 1, E0); add(0, 1, EPH); add(0, 1, EH);
        add(1, 1, EH); add(1, 1, ER); add(1, 1, E0);
        // Release coincides with cnt == LONG-1: release wins, no long.
        add(0, 1, E0); add(0, 1, EPH);
        add(0, 1, EH); add(0, 1, EH); add(0, 1, EH); add(0, 1, EH);
        add(0, 1, EH); add(0, 1, EH); add(1, 1, EH);
        add(1, 1, ER); add(1, 1, E0);
        // Disable in PRESS, re-enable while held, then fresh press.
        add(0, 1, E0); add(0, 1, EPH); add(0, 0, E0); add(0, 1, E0);
        add(0, 1, E0); add(1, 1, E0); add(1, 1, E0);
        add(0, 1, E0); add(0, 1, EPH); add(1, 1, EH); add(1, 1, ER); add(1, 1, E0);

        foreach (vecs[i]) begin
            p_level  = vecs[i].lvl;
            p_enable = vecs[i].en;
            step();
            check($sformatf("vec %0d", i), o1, vecs[i].exp);
        end

        // Disable while in LONG, then re-enable held, release, press again.
        for (int e = 1; e <= 22; e++) begin
            p_level  = ((e <= 15) || (e >= 18 && e <= 19)) ? 1'b0 : 1'b1;
            p_enable = (e == 11 || e == 12) ? 1'b0 : 1'b1;
            step();
            if (e == 2 || e == 19)           exp = EPH;
            else if (e >= 3 && e <= 9)       exp = EH;
            else if (e == 10)                exp = ELH;
            else if (e == 20)                exp = EH;
            else if (e == 21)                exp = ER;
            else                             exp = E0;
            check($sformatf("disable edge %0d", e), o1, exp);
        end

        // Asynchronous reset while held, button still held at release.
        p_level = 1'b0;
        step(); check("pre-reset e1", o1, E0);
        step(); check("pre-reset press", o1, EPH);
        step(); check("pre-reset held", o1, EH);
        #1 reset_n = 1'b0;
        #1 check("async reset clear", o1, E0);
        step(); check("reset held low", o1, E0);
        reset_n = 1'b1;
        step(); check("post-reset e1", o1, E0);
        step(); check("post-reset press", o1, EPH);
        step(); check("post-reset held", o1, EH);
        p_level = 1'b1;
        step(); check("post-reset rel sampled", o1, EH);
        step(); check("post-reset release", o1, ER);
        step(); check("post-reset idle", o1, E0);

        // Active-high instance with repeat disabled: no repeat after long.
        q_level = 1'b1;
        step(); check("sat e1", o2, E0);
        step(); check("sat press", o2, EPH);
        for (int e = 3; e <= 9; e++) begin
            step(); check($sformatf("sat press hold %0d", e), o2, EH);
        end
        step(); check("sat long", o2, ELH);
        for (int k = 0; k < 266; k++) begin
            step(); check($sformatf("sat long hold %0d", k), o2, EH);
        end
        q_level = 1'b0;
        step(); check("sat rel sampled", o2, EH);
        step(); check("sat release", o2, ER);
        step(); check("sat idle", o2, E0);
        check("dut idle at end", o1, E0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
Consumes the debounced level from the button/strap debounce stage and turns it into single-cycle event pulses: press, release, long-press and auto-repeat. It also provides a held-level flag. It sits directly downstream of the debouncer and feeds the control/status logic, which needs events rather than levels. All outputs are registered and run in one clock domain.

Parameters:
ACTIVE_LOW, 1, 1 = input low means pressed (the debouncer idles high); 0 = input high means pressed.
LONG_CYCLES, 1000, cycles from the press pulse to the long pulse; legal range 2..2^CNT_W-1.
REPEAT_CYCLES, 250, period of the repeat pulses once long-press is reached; 0 disables repeat.
CNT_W, 16, width of the internal counter; must hold max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
clk  in  1  system clock.
reset_n  in  1  reset, asynchronous, active-low.
p_level  in  1  debounced level from the debouncer.
p_enable  in  1  event generation enable.
p_press  out  1  one-cycle pulse on press.
p_release  out  1  one-cycle pulse on release.
p_long  out  1  one-cycle pulse when the long-press threshold is reached.
p_repeat  out  1  one-cycle pulse every REPEAT_CYCLES while in long-press.
p_held  out  1  high while in the PRESS or LONG state.

Behaviour:
- Reset (async assert, sync release):
  - lvl_q and lvl_prev = inactive level (1 when ACTIVE_LOW = 1).
  - State = IDLE, cnt = 0.
  - All outputs = 0.
- Input pipeline:
  - lvl_q samples p_level every edge; lvl_prev samples lvl_q.
  - pressed = (lvl_q == active level).
  - press edge = pressed && !prev_pressed; release edge = the reverse.
- Latency: a p_level change sampled at edge N produces its pulse registered at edge N+1, high for exactly one cycle.
- IDLE:
  - press edge -> PRESS, p_press = 1, cnt = 0.
- PRESS:
  - release edge -> IDLE, p_release = 1.
  - else if cnt == LONG_CYCLES-1 -> LONG, p_long = 1, cnt = 0.
  - else cnt++.
- LONG:
  - release edge -> IDLE, p_release = 1.
  - else if REPEAT_CYCLES != 0 and cnt == REPEAT_CYCLES-1 -> p_repeat = 1, cnt = 0.
  - else cnt++ (saturates at all-ones when REPEAT_CYCLES = 0; never wraps).
- Timing: p_long fires LONG_CYCLES edges after p_press; repeats follow every REPEAT_CYCLES edges.
- Simultaneous events: a release on the threshold cycle wins. p_release is asserted, and p_long/p_repeat are suppressed. Pulses are mutually exclusive in any cycle.
- p_enable = 0:
  - Next edge: state -> IDLE, cnt -> 0, all outputs 0; no p_release is emitted.
  - The input pipeline keeps running.
  - Re-enabling while the button is held produces no p_press; a fresh press edge is required.
- Reset asserted mid-press: everything clears immediately with no pulses.
- Button held across reset release: lvl_prev is inactive, so a press edge is seen and p_press fires at the 2nd edge after release.
- p_held is registered and goes high on the same edge as p_press. It goes low on the same edge as p_release, or on disable.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, PRESS, LONG; 2-bit encoding);
  - the polarity constants ACTIVE_LOW_LVL / ACTIVE_HIGH_LVL;
  - a function to compute the inactive reset level from ACTIVE_LOW.
- One natural sub-module, `sync_edge_detect`: the lvl_q/lvl_prev registers plus rise/fall outputs, with the same clk/reset_n and a reset-level parameter. Other designs can reuse it.
- The FSM and counter stay in the top module.

Test Plan:
- ACTIVE_LOW=1, LONG=8, REPEAT=4, enable=1. Drive p_level 1->0 sampled at edge 10. p_press is high during the cycle after edge 11 only, and p_held rises at edge 11.
- Hold for 30 cycles:
  - p_long at edge 19;
  - p_repeat at edges 23, 27, 31, 35, 39;
  - release sampled at edge 40 gives p_release at edge 41 and p_held low;
  - no other pulses.
- Short press: low for 3 cycles. Expect p_press, then p_release; p_long never fires.
- Release sampled so that it coincides with cnt == 7 in PRESS. Expect p_release = 1, p_long = 0, state IDLE.
- Disable while held in LONG:
  - next edge, all outputs 0 and no p_release;
  - re-enable while still held gives no p_press;
  - release then press gives normal p_press.
- Reset asserted mid-hold: outputs clear asynchronously. With the button still held at reset release, p_press fires at the 2nd edge after release. With REPEAT=0, no p_repeat appears after p_long for 2^CNT_W+10 cycles.
